// File: rtl/router_out_reader.sv
// ---------------------------------------------------------------------------
// router_out_reader
//
// Destination-side consumer for one router output port. It watches the
// router's vld_out, drives read_enb back into the router FIFO and pops one
// packet at a time: a header byte {len[7:2], addr[1:0]}, len payload bytes
// and a trailing parity byte. Payload bytes are streamed out and the parity
// and address are checked. A router soft reset (sft_rst) aborts the packet.
//
// Parameters
//   PORT_ID    Address this reader serves; the header addr field must match.
//   RD_DELAY   Idle cycles between seeing vld_out and the header read (0..27).
//
// Ports
//   clk         in   1  Clock.
//   rst         in   1  Synchronous reset, active-low.
//   vld_out     in   1  Router output FIFO not empty.
//   sft_rst     in   1  Router soft reset for this port (timeout flush).
//   data_in     in   8  Router FIFO data, valid 1 cycle after read_enb.
//   read_enb    out  1  Registered FIFO read request.
//   byte_out    out  8  Payload byte.
//   byte_valid  out  1  1-cycle qualifier for byte_out.
//   len_out     out  6  Payload length of the current packet.
//   pkt_done    out  1  1-cycle pulse when the parity byte is captured.
//   pkt_err     out  1  With pkt_done: parity mismatch.
//   addr_err    out  1  With pkt_done: header addr != PORT_ID.
//   pkt_abort   out  1  1-cycle pulse: packet discarded due to sft_rst.
//   busy        out  1  FSM not idle.
// ---------------------------------------------------------------------------
module router_out_reader #(
    parameter logic [1:0]  PORT_ID  = 2'd0,
    parameter int unsigned RD_DELAY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_out,
    input  logic       sft_rst,
    input  logic [7:0] data_in,
    output logic       read_enb,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [5:0] len_out,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic       addr_err,
    output logic       pkt_abort,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR_RD,
        S_HDR_CAP,
        S_BODY,
        S_DONE
    } state_t;

    // Last value of the delay counter before the header read goes out.
    localparam logic [4:0] DLY_LAST = (RD_DELAY > 0) ? 5'(RD_DELAY - 1) : 5'd0;

    state_t     state_q, state_d;
    logic [4:0] dly_q, dly_d;
    logic [6:0] issued_q, issued_d;       // body reads issued (payload + parity)
    logic [6:0] rx_cnt_q, rx_cnt_d;       // body bytes captured
    logic [6:0] remaining_q, remaining_d; // len + 1
    logic [7:0] par_acc_q, par_acc_d;     // header ^ payload
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic       rd_q, rd_d;               // capture strobe: read_enb delayed 1
    logic       read_enb_q, read_enb_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       pkt_done_q, pkt_done_d;
    logic       pkt_err_q, pkt_err_d;
    logic       addr_err_q, addr_err_d;
    logic       pkt_abort_q, pkt_abort_d;

    logic [6:0] rx_nxt;
    assign rx_nxt = rx_cnt_q + 7'd1;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        issued_d     = issued_q;
        rx_cnt_d     = rx_cnt_q;
        remaining_d  = remaining_q;
        par_acc_d    = par_acc_q;
        addr_d       = addr_q;
        len_d        = len_q;
        rd_d         = read_enb_q;
        read_enb_d   = 1'b0;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_err_d    = 1'b0;
        addr_err_d   = 1'b0;
        pkt_abort_d  = 1'b0;

        if (state_q != S_IDLE && sft_rst) begin
            // Router flushed its FIFO: drop everything, including the
            // capture of a read that is already in flight.
            state_d     = S_IDLE;
            rd_d        = 1'b0;
            pkt_abort_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (vld_out) begin
                        dly_d = 5'd0;
                        if (RD_DELAY == 0) begin
                            state_d    = S_HDR_RD;
                            read_enb_d = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dly_q == DLY_LAST) begin
                        state_d    = S_HDR_RD;
                        read_enb_d = 1'b1;
                    end else begin
                        dly_d = dly_q + 5'd1;
                    end
                end
                S_HDR_RD: begin
                    // read_enb is high in this state; header arrives next cycle.
                    state_d = S_HDR_CAP;
                end
                S_HDR_CAP: begin
                    len_d       = data_in[7:2];
                    addr_d      = data_in[1:0];
                    remaining_d = {1'b0, data_in[7:2]} + 7'd1;
                    par_acc_d   = data_in;
                    issued_d    = 7'd0;
                    rx_cnt_d    = 7'd0;
                    state_d     = S_BODY;
                end
                S_BODY: begin
                    if (vld_out && (issued_q < remaining_q)) begin
                        read_enb_d = 1'b1;
                        issued_d   = issued_q + 7'd1;
                    end
                    if (rd_q) begin
                        rx_cnt_d = rx_nxt;
                        if (rx_nxt <= {1'b0, len_q}) begin
                            byte_out_d   = data_in;
                            byte_valid_d = 1'b1;
                            par_acc_d    = par_acc_q ^ data_in;
                        end else begin
                            // Parity byte: XOR of header, payload and parity is 0.
                            pkt_done_d = 1'b1;
                            pkt_err_d  = ((par_acc_q ^ data_in) != 8'd0);
                            addr_err_d = (addr_q != PORT_ID);
                            state_d    = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dly_q        <= 5'd0;
            issued_q     <= 7'd0;
            rx_cnt_q     <= 7'd0;
            remaining_q  <= 7'd0;
            par_acc_q    <= 8'd0;
            addr_q       <= 2'd0;
            len_q        <= 6'd0;
            rd_q         <= 1'b0;
            read_enb_q   <= 1'b0;
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            pkt_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            issued_q     <= issued_d;
            rx_cnt_q     <= rx_cnt_d;
            remaining_q  <= remaining_d;
            par_acc_q    <= par_acc_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rd_q         <= rd_d;
            read_enb_q   <= read_enb_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            pkt_done_q   <= pkt_done_d;
            pkt_err_q    <= pkt_err_d;
            addr_err_q   <= addr_err_d;
            pkt_abort_q  <= pkt_abort_d;
        end
    end

    assign read_enb   = read_enb_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign len_out    = len_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_err    = pkt_err_q;
    assign addr_err   = addr_err_q;
    assign pkt_abort  = pkt_abort_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_router_out_reader.sv
// ---------------------------------------------------------------------------
// tb_router_out_reader
//
// Two readers (RD_DELAY 0 and 27, both PORT_ID 1) share one router FIFO
// model; sel picks which reader's read_enb pops the FIFO and whose outputs
// the monitor watches. Expected events are pushed into a scoreboard queue
// when a packet is queued; the monitor pops and compares on every
// byte_valid / pkt_done / pkt_abort.
// ---------------------------------------------------------------------------
module tb_router_out_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld_out = 1'b0;
    logic       sft_rst = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       sel;

    always #5 clk = ~clk;

    logic       re0, bv0, pd0, pe0, ae0, pa0, by0;
    logic [7:0] bo0;
    logic [5:0] lo0;
    logic       re1, bv1, pd1, pe1, ae1, pa1, by1;
    logic [7:0] bo1;
    logic [5:0] lo1;

    router_out_reader #(.PORT_ID(2'd1), .RD_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .vld_out(vld_out), .sft_rst(sft_rst),
        .data_in(data_in), .read_enb(re0), .byte_out(bo0), .byte_valid(bv0),
        .len_out(lo0), .pkt_done(pd0), .pkt_err(pe0), .addr_err(ae0),
        .pkt_abort(pa0), .busy(by0)
    );

    router_out_reader #(.PORT_ID(2'd1), .RD_DELAY(27)) dut27 (
        .clk(clk), .rst(rst), .vld_out(vld_out), .sft_rst(sft_rst),
        .data_in(data_in), .read_enb(re1), .byte_out(bo1), .byte_valid(bv1),
        .len_out(lo1), .pkt_done(pd1), .pkt_err(pe1), .addr_err(ae1),
        .pkt_abort(pa1), .busy(by1)
    );

    logic       m_re, m_bv, m_pd, m_pe, m_ae, m_pa, m_by;
    logic [7:0] m_bo;
    logic [5:0] m_lo;
    assign m_re = sel ? re1 : re0;
    assign m_bv = sel ? bv1 : bv0;
    assign m_bo = sel ? bo1 : bo0;
    assign m_lo = sel ? lo1 : lo0;
    assign m_pd = sel ? pd1 : pd0;
    assign m_pe = sel ? pe1 : pe0;
    assign m_ae = sel ? ae1 : ae0;
    assign m_pa = sel ? pa1 : pa0;
    assign m_by = sel ? by1 : by0;

    // ------------------------------------------------------------------
    // Router FIFO model: pop on read_enb, data valid the next cycle,
    // soft reset on request or after 30 cycles of vld_out with no read.
    // ------------------------------------------------------------------
    logic [7:0] fifo[$];
    logic       hold;
    logic       sft_req;
    logic       flush;
    int         tmo;
    int         n_sft = 0;
    int         underflow = 0;

    always @(posedge clk) begin
        if (!rst) begin
            fifo.delete();
            tmo = 0;
            vld_out <= 1'b0;
            sft_rst <= 1'b0;
            data_in <= 8'd0;
        end else begin
            flush = sft_req;
            if (m_re && !sft_rst && !flush) begin
                if (fifo.size() > 0) data_in <= fifo.pop_front();
                else underflow++;
            end
            if (vld_out && !m_re) tmo++;
            else tmo = 0;
            if (tmo >= 30) flush = 1'b1;
            if (flush) begin
                fifo.delete();
                tmo = 0;
                n_sft++;
            end
            sft_rst <= flush;
            vld_out <= (fifo.size() > 0) && !hold;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {EV_BYTE, EV_DONE, EV_ABORT} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
        logic       perr;
        logic       aerr;
        logic [5:0] len;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0, n_miss = 0;
    int  n_bytes = 0, n_done = 0, n_abort = 0, n_reads = 0, n_viol = 0;
    logic vld_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", {30'd0, k}, 32'd3);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", {30'd0, k}, {30'd0, e.kind});
            if (e.kind == k) begin
                case (k)
                    EV_BYTE: check("byte_out", {24'd0, m_bo}, {24'd0, e.data});
                    EV_DONE: begin
                        check("pkt_err", {31'd0, m_pe}, {31'd0, e.perr});
                        check("addr_err", {31'd0, m_ae}, {31'd0, e.aerr});
                        check("len_out", {26'd0, m_lo}, {26'd0, e.len});
                    end
                    default: check("busy_at_abort", {31'd0, m_by}, 32'd0);
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (m_re) n_reads++;
        if (m_re && !vld_prev) n_viol++;
        if (m_pd || m_pa) check("done_abort_excl", {31'd0, m_pd & m_pa}, 32'd0);
        if (m_bv) begin
            n_bytes++;
            pop_cmp(EV_BYTE);
        end
        if (m_pd) begin
            n_done++;
            pop_cmp(EV_DONE);
        end
        if (m_pa) begin
            n_abort++;
            pop_cmp(EV_ABORT);
        end
        vld_prev = vld_out;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] hdr, input logic [63:0] pl, input logic [7:0] par);
        fifo.push_back(hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++) fifo.push_back(pl[8*i +: 8]);
        fifo.push_back(par);
    endtask

    task automatic expect_bytes(input int n, input logic [63:0] pl);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e = '{kind: EV_BYTE, data: pl[8*i +: 8], perr: 1'b0, aerr: 1'b0, len: 6'd0};
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_pkt(input logic [7:0] hdr, input logic [63:0] pl,
                              input logic perr, input logic aerr);
        ev_t e;
        expect_bytes(int'(hdr[7:2]), pl);
        e = '{kind: EV_DONE, data: 8'd0, perr: perr, aerr: aerr, len: hdr[7:2]};
        exp_q.push_back(e);
    endtask

    function automatic int counter(input int which);
        case (which)
            0:       return n_bytes;
            1:       return n_done;
            default: return n_abort;
        endcase
    endfunction

    // Bounded wait for an event counter to reach a target.
    task automatic wait_cnt(input string name, input int which, input int target, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (counter(which) >= target) break;
            step();
        end
        check(name, {31'd0, counter(which) >= target}, 32'd1);
    endtask

    function automatic logic [20:0] outs0();
        return {re0, bv0, bo0, lo0, pd0, pe0, ae0, pa0, by0};
    endfunction

    function automatic logic [20:0] outs1();
        return {re1, bv1, bo1, lo1, pd1, pe1, ae1, pa1, by1};
    endfunction

    localparam int W_BYTE  = 0;
    localparam int W_DONE  = 1;
    localparam int W_ABORT = 2;

    initial begin
        int r0, b0, d0, a0, s0, cyc;
        rst = 1'b0; sel = 1'b0; hold = 1'b0; sft_req = 1'b0;
        repeat (3) step();
        check("reset_outs_d0", {11'd0, outs0()}, 32'd0);
        check("reset_outs_d27", {11'd0, outs1()}, 32'd0);
        rst = 1'b1;
        repeat (2) step();

        // T1: clean packet, len 3
        r0 = n_reads; d0 = n_done;
        expect_pkt(8'h0D, 64'h332211, 1'b0, 1'b0);
        load(8'h0D, 64'h332211, 8'h0D);
        wait_cnt("t1_done", W_DONE, d0 + 1, 100);
        check("t1_reads", n_reads - r0, 32'd5);
        repeat (2) step();

        // T2: parity error
        d0 = n_done;
        expect_pkt(8'h0D, 64'h332211, 1'b1, 1'b0);
        load(8'h0D, 64'h332211, 8'h0E);
        wait_cnt("t2_done", W_DONE, d0 + 1, 100);
        repeat (2) step();

        // T3: zero length
        r0 = n_reads; d0 = n_done; b0 = n_bytes;
        expect_pkt(8'h01, 64'h0, 1'b0, 1'b0);
        load(8'h01, 64'h0, 8'h01);
        wait_cnt("t3_done", W_DONE, d0 + 1, 100);
        check("t3_reads", n_reads - r0, 32'd2);
        check("t3_no_bytes", n_bytes - b0, 32'd0);
        repeat (2) step();

        // T4: address mismatch
        d0 = n_done;
        expect_pkt(8'h0C, 64'h030201, 1'b0, 1'b1);
        load(8'h0C, 64'h030201, 8'h0C);
        wait_cnt("t4_done", W_DONE, d0 + 1, 100);
        repeat (2) step();

        // T6: vld_out drops for 5 cycles mid-payload
        d0 = n_done; b0 = n_bytes; r0 = n_reads;
        expect_pkt(8'h15, 64'h5040302010, 1'b0, 1'b0);
        load(8'h15, 64'h5040302010, 8'h05);
        wait_cnt("t6_two_bytes", W_BYTE, b0 + 2, 100);
        hold = 1'b1;
        n_viol = 0;
        repeat (5) step();
        hold = 1'b0;
        wait_cnt("t6_done", W_DONE, d0 + 1, 100);
        check("t6_read_while_vld_low", n_viol, 32'd0);
        check("t6_reads", n_reads - r0, 32'd7);
        repeat (2) step();

        // T7: soft reset after the first payload byte; one more is in flight
        a0 = n_abort; b0 = n_bytes; d0 = n_done;
        begin
            ev_t e;
            expect_bytes(2, 64'h0201);
            e = '{kind: EV_ABORT, data: 8'd0, perr: 1'b0, aerr: 1'b0, len: 6'd0};
            exp_q.push_back(e);
        end
        load(8'h15, 64'h0504030201, 8'h14);
        wait_cnt("t7_first_byte", W_BYTE, b0 + 1, 100);
        sft_req = 1'b1;
        step();
        sft_req = 1'b0;
        wait_cnt("t7_abort", W_ABORT, a0 + 1, 20);
        check("t7_no_done", n_done - d0, 32'd0);
        repeat (3) step();
        check("t7_busy_after", {31'd0, by0}, 32'd0);
        d0 = n_done;
        expect_pkt(8'h0D, 64'h332211, 1'b0, 1'b0);
        load(8'h0D, 64'h332211, 8'h0D);
        wait_cnt("t7_next_done", W_DONE, d0 + 1, 100);
        repeat (2) step();

        // T5: RD_DELAY=27 reader
        rst = 1'b0; step();
        sel = 1'b1; step();
        rst = 1'b1; step();
        d0 = n_done; s0 = n_sft;
        expect_pkt(8'h09, 64'h55AA, 1'b0, 1'b0);
        load(8'h09, 64'h55AA, 8'hF6);
        for (int c = 0; c < 10; c++) begin
            if (vld_out) break;
            step();
        end
        cyc = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            cyc++;
            if (m_re) break;
        end
        check("t5_first_read_cycle", cyc, 32'd28);
        wait_cnt("t5_done", W_DONE, d0 + 1, 100);
        check("t5_no_sft_rst", n_sft - s0, 32'd0);
        repeat (2) step();

        // Reset mid-packet on the RD_DELAY=0 reader
        rst = 1'b0; step();
        sel = 1'b0; step();
        rst = 1'b1; step();
        b0 = n_bytes;
        expect_bytes(1, 64'h11);
        load(8'h0D, 64'h332211, 8'h0D);
        wait_cnt("rst_first_byte", W_BYTE, b0 + 1, 100);
        rst = 1'b0;
        step();
        check("rst_mid_outs", {11'd0, outs0()}, 32'd0);
        step();
        rst = 1'b1;
        repeat (4) step();
        check("rst_no_more_bytes", n_bytes - b0, 32'd1);

        check("sb_empty", exp_q.size(), 32'd0);
        check("fifo_underflow", underflow, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
